// File: rtl/apb_uart_tx.sv
// rtl/apb_uart_tx.sv - APB slave with TX FIFO and UART serializer
//
// Purpose:
//   Zero-wait-state APB slave. The CPU pushes bytes into a TX FIFO through
//   TXDATA; a serializer drains the FIFO as 8N1 frames on txd. The baud
//   divisor, TX enable and FIFO/serializer status are visible on APB.
//
// Ports:
//   PCLK, PRESETn   clock and asynchronous active-low reset
//   PSELx, PENABLE, PWRITE, PADDR, PWDATA   APB request (PADDR[4:2] decoded)
//   PRDATA, PREADY, PSLVERR                 APB response (PREADY tied high)
//   txd             serial output, idle high
//   tx_idle         FIFO empty and serializer idle
//
// Build option:
//   UART_PARITY_EN  adds an even parity bit between DATA and STOP (11-bit frame)

module apb_uart_tx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 867
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSELx,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        txd,
  output logic        tx_idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [2:0]    reg_addr;
  logic          access;
  logic          wr_access;

  logic [15:0]   baud_div;
  logic          tx_en;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  state_t        state;
  logic [15:0]   div_lat;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    frame_data;
  logic          bit_done;
  logic          busy;

  logic          unused_bits;

  assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:16]};

  assign reg_addr  = PADDR[4:2];
  assign access    = PSELx & PENABLE;
  assign wr_access = access & PWRITE;

  assign empty = (count == '0);
  // Full uses the count before the edge, so a push while full is rejected
  // even if the serializer pops on the same edge.
  assign full  = (count == FULL_COUNT);
  assign push  = wr_access & (reg_addr == 3'd0) & ~full;

  // div_lat is captured at frame start so divisor writes only affect later frames.
  assign bit_done = (baud_cnt == div_lat);
  assign busy     = (state != S_IDLE);

  // Pop either from IDLE or at the end of STOP (back-to-back, no idle cycle).
  assign pop = tx_en & ~empty &
               ((state == S_IDLE) | ((state == S_STOP) & bit_done));

  assign tx_idle = empty & ~busy;
  assign PREADY  = 1'b1;

  // Read data and error response only exist during the access phase.
  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (access) begin
      case (reg_addr)
        3'd0: PSLVERR = ~PWRITE | full;
        3'd1: begin
          if (PWRITE) PSLVERR = 1'b1;
          else        PRDATA  = {16'b0, 8'(count), 5'b0, busy, full, empty};
        end
        3'd2: if (!PWRITE) PRDATA = {16'b0, baud_div};
        3'd3: if (!PWRITE) PRDATA = {31'b0, tx_en};
        default: PSLVERR = 1'b1;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      baud_div <= 16'(DEFAULT_DIV);
      tx_en    <= 1'b0;
    end else if (wr_access) begin
      if (reg_addr == 3'd2) baud_div <= PWDATA[15:0];
      if (reg_addr == 3'd3) tx_en    <= PWDATA[0];
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge PCLK) begin
    if (push) fifo_mem[wr_ptr] <= PWDATA[7:0];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Serializer. txd is registered; every transition that changes the line
  // level sets txd on the same edge as the state change.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= S_IDLE;
      txd        <= 1'b1;
      div_lat    <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      frame_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            frame_data <= fifo_mem[rd_ptr];
            div_lat    <= baud_div;
            baud_cnt   <= '0;
            txd        <= 1'b0;
            state      <= S_START;
          end
        end

        S_START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd      <= frame_data[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              txd   <= ^frame_data;
              state <= S_PARITY;
`else
              txd   <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= frame_data[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            baud_cnt <= '0;
            txd      <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
`endif

        S_STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (pop) begin
              frame_data <= fifo_mem[rd_ptr];
              div_lat    <= baud_div;
              txd        <= 1'b0;
              state      <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        default: begin
          state <= S_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_tx.sv
// tb/tb_apb_uart_tx.sv - self-checking bench for apb_uart_tx

module tb_apb_uart_tx;

`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSELx = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        txd;
  logic        tx_idle;

  int checks = 0;
  int failures = 0;

  logic       trace_on = 1'b0;
  logic       trace[$];
  logic [7:0] got[$];
  logic [7:0] expq[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[19];

  apb_uart_tx dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSELx   (PSELx),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .txd     (txd),
    .tx_idle (tx_idle)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    forever begin
      @(posedge PCLK);
      #1;
      if (trace_on) trace.push_back(txd);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // One APB transfer; the access edge is the posedge just before return.
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err);
    @(negedge PCLK);
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    #1;
    check("setup_prdata", PRDATA, 32'h0);
    check("setup_pslverr", {31'b0, PSLVERR}, 32'h0);
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    rdata = PRDATA;
    err   = PSLVERR;
    @(posedge PCLK);
    #1;
    PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data,
                    input logic exp_err);
    logic [31:0] rd;
    logic        e;
    apb(1'b1, addr, data, rd, e);
    check(name, {31'b0, e}, {31'b0, exp_err});
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        e;
    apb(1'b0, addr, 32'h0, rd, e);
    check(name, rd, exp);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (!tx_idle && n < bound) begin
      @(posedge PCLK);
      #1;
      n++;
    end
    check(name, {31'b0, tx_idle}, 32'h1);
  endtask

  // Expected line levels of one frame: start, data LSB first, [parity], stop.
  function automatic void frame_bits(input logic [7:0] b, output logic bits[NB]);
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = b[k];
`ifdef UART_PARITY_EN
    bits[9] = ^b;
`endif
    bits[NB-1] = 1'b1;
  endfunction

  // Line receiver: each frame is NB bit slots of d+1 samples, every slot constant.
  task automatic decode(input int d, output int nerr);
    int         i;
    int         w;
    logic       bv;
    logic [7:0] v;
    i = 0;
    w = d + 1;
    nerr = 0;
    v = '0;
    got.delete();
    while (i < trace.size()) begin
      if (trace[i] == 1'b1) begin
        i++;
      end else if (i + NB * w > trace.size()) begin
        nerr++;
        break;
      end else begin
        for (int k = 0; k < NB; k++) begin
          bv = trace[i + k * w];
          for (int j = 1; j < w; j++)
            if (trace[i + k * w + j] !== bv) nerr++;
          if (k >= 1 && k <= 8) v[k-1] = bv;
`ifdef UART_PARITY_EN
          if (k == 9 && bv !== ^v) nerr++;
`endif
          if (k == NB - 1 && bv !== 1'b1) nerr++;
        end
        got.push_back(v);
        i += NB * w;
      end
    end
  endtask

  task automatic compare_bytes(input string name);
    check({name, "_count"}, got.size(), expq.size());
    for (int k = 0; k < expq.size() && k < got.size(); k++)
      check($sformatf("%s_byte%0d", name, k), {24'b0, got[k]}, {24'b0, expq[k]});
  endtask

  initial begin
    logic        bits[NB];
    int          errs;
    int          nerr;
    int          d;
    int          n;
    logic [7:0]  b;

    // Reset state
    #12;
    check("rst_txd", {31'b0, txd}, 32'h1);
    check("rst_tx_idle", {31'b0, tx_idle}, 32'h1);
    check("rst_pready", {31'b0, PREADY}, 32'h1);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Register map vectors
    tbl[0]  = '{1'b0, 32'h04,       32'h0,        1'b0, 32'h1};
    tbl[1]  = '{1'b0, 32'h08,       32'h0,        1'b0, 32'd867};
    tbl[2]  = '{1'b0, 32'h0C,       32'h0,        1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h10,       32'h0,        1'b1, 32'h0};
    tbl[4]  = '{1'b0, 32'h00,       32'h0,        1'b1, 32'h0};
    tbl[5]  = '{1'b1, 32'h04,       32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, 32'h14,       32'h0000FFFF, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 32'h08,       32'h0,        1'b0, 32'd867};
    tbl[8]  = '{1'b0, 32'h04,       32'h0,        1'b0, 32'h1};
    tbl[9]  = '{1'b0, 32'h0C,       32'h0,        1'b0, 32'h0};
    tbl[10] = '{1'b1, 32'h08,       32'hABCD1234, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 32'hFFFFFF08, 32'h0,        1'b0, 32'h1234};
    tbl[12] = '{1'b1, 32'h0C,       32'hFFFFFFFE, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 32'h0C,       32'h0,        1'b0, 32'h0};
    tbl[14] = '{1'b0, 32'h1C,       32'h0,        1'b1, 32'h0};
    tbl[15] = '{1'b0, 32'h08,       32'h0,        1'b0, 32'h1234};
    tbl[16] = '{1'b1, 32'h0C,       32'h3,        1'b0, 32'h0};
    tbl[17] = '{1'b0, 32'h0C,       32'h0,        1'b0, 32'h1};
    tbl[18] = '{1'b1, 32'h0C,       32'h0,        1'b0, 32'h0};

    for (int i = 0; i < 19; i++) begin
      logic [31:0] rd;
      logic        e;
      apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, e);
      check($sformatf("vec%0d_pslverr", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
      if (!tbl[i].wr) check($sformatf("vec%0d_prdata", i), rd, tbl[i].exp_rdata);
    end

    // Single 0xA5 frame, 4 cycles per bit, first bit right after the next edge
    wr("a5_div", 32'h08, 32'd3, 1'b0);
    wr("a5_ctrl", 32'h0C, 32'h1, 1'b0);
    wr("a5_push", 32'h00, 32'hA5, 1'b0);
    frame_bits(8'hA5, bits);
    errs = 0;
    for (int i = 0; i < NB * 4; i++) begin
      @(posedge PCLK);
      #1;
      if (txd !== bits[i / 4]) errs++;
    end
    check("a5_wave_errs", errs, 0);
    check("a5_busy_last_cycle", {31'b0, tx_idle}, 32'h0);
    @(posedge PCLK);
    #1;
    check("a5_idle_after", {31'b0, tx_idle}, 32'h1);

`ifdef UART_PARITY_EN
    // 0x07 with divisor 0: 0,1,1,1,0,0,0,0,0,1,1
    begin
      logic [10:0] pexp;
      pexp = 11'b110_0000_1110;
      wr("par_div", 32'h08, 32'd0, 1'b0);
      wr("par_push", 32'h00, 32'h07, 1'b0);
      errs = 0;
      for (int i = 0; i < 11; i++) begin
        @(posedge PCLK);
        #1;
        if (txd !== pexp[i]) errs++;
      end
      check("par_wave_errs", errs, 0);
    end
`endif

    // Fill FIFO with TX disabled, overflow, then drain in order
    wr("full_ctrl0", 32'h0C, 32'h0, 1'b0);
    wr("full_div0", 32'h08, 32'h0, 1'b0);
    expq.delete();
    for (int i = 0; i < 17; i++) begin
      b = 8'(i * 37 + 5);
      if (i < 16) expq.push_back(b);
      wr($sformatf("full_push%0d", i), 32'h00, {24'b0, b}, (i == 16));
    end
    rd_chk("full_status", 32'h04, 32'h00001002);
    trace.delete();
    trace_on = 1'b1;
    wr("full_ctrl1", 32'h0C, 32'h1, 1'b0);
    wait_idle("full_drain_timeout", 4000);
    repeat (3) @(posedge PCLK);
    #2;
    trace_on = 1'b0;
    decode(0, nerr);
    check("full_decode_errs", nerr, 0);
    compare_bytes("full");

    // Random bursts with random divisors and random gaps between writes
    for (int burst = 0; burst < 5; burst++) begin
      d = $urandom_range(0, 3);
      wr("rnd_div", 32'h08, d, 1'b0);
      expq.delete();
      trace.delete();
      trace_on = 1'b1;
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        expq.push_back(b);
        wr("rnd_push", 32'h00, {24'b0, b}, 1'b0);
        repeat ($urandom_range(0, 2 * NB * (d + 1))) @(posedge PCLK);
      end
      wait_idle("rnd_drain_timeout", 3000);
      repeat (3) @(posedge PCLK);
      #2;
      trace_on = 1'b0;
      decode(d, nerr);
      check($sformatf("rnd%0d_decode_errs", burst), nerr, 0);
      compare_bytes($sformatf("rnd%0d", burst));
    end

    // Reset asserted during DATA bit 3 of a 0x00 frame, with a byte still queued
    wr("rst_div", 32'h08, 32'd3, 1'b0);
    wr("rst_push0", 32'h00, 32'h00, 1'b0);
    wr("rst_push1", 32'h00, 32'h11, 1'b0);
    repeat (16) @(posedge PCLK);
    #1;
    check("rst_mid_txd_low", {31'b0, txd}, 32'h0);
    #2;
    PRESETn = 1'b0;
    #1;
    check("rst_mid_txd_high", {31'b0, txd}, 32'h1);
    check("rst_mid_tx_idle", {31'b0, tx_idle}, 32'h1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    rd_chk("rst_mid_status", 32'h04, 32'h00000001);
    rd_chk("rst_mid_ctrl", 32'h0C, 32'h0);
    rd_chk("rst_mid_baud", 32'h08, 32'd867);
    check("rst_mid_txd_after", {31'b0, txd}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
